status_read_irq: RTL and testbench
==================================

# status_read_irq

Parametrised successor of the byte-serial status collector, running in a single clock domain. Subsystems deliver status packets over the shared `ad`/`rq` byte bus; each packet is assembled into a 32-bit word and stored in a status RAM that software reads. The block adds interrupt generation for the low `IRQ_CELLS` addresses, plus a drop counter for out-of-range addresses. It sits between the status daisy-chain root and the AXI register read multiplexer.

## Interface
Parameters:
- `STATUS_DEPTH`, 6: log2 of RAM cells; legal range 4..8.
- `PAYLOAD_BYTES`, 3: payload bytes stored after the sequence byte; legal range 1..3.
- `IRQ_CELLS`, 16: addresses 0..`IRQ_CELLS`-1 can raise an interrupt; must satisfy `IRQ_CELLS` ≤ 2^`STATUS_DEPTH`, ≤ 32.

Ports:
- `clk`  in  1  the single clock.
- `rst`  in  1  synchronous, active-low reset.
- `ad`  in  8  byte-serial status data.
- `rq`  in  1  packet request; high for the whole packet.
- `start`  out  1  = `rq` && !`rq_r`; acknowledges the address byte.
- `rd_addr`  in  `STATUS_DEPTH`  status RAM read address.
- `rd_en`  in  1  read strobe.
- `rd_data`  out  32  RAM word.
- `rd_valid`  out  1  `rd_data` valid.
- `cmd_we`  in  1  control write strobe.
- `cmd_addr`  in  2  control register select: 0 = mask set, 1 = mask clear, 2 = pending W1C, 3 = read-only drop count.
- `cmd_wdata`  in  32  control write data.
- `cmd_rdata`  out  32  control read data; 1-cycle registered, selected by `cmd_addr`: mask / pending / pending&mask / drop count.
- `irq`  out  1  interrupt request.

## Operation
Deserializer FSM states and transitions:
- **IDLE**: on `start`, capture `ad` as the address, clear the assembly word, and go to SEQ.
- **SEQ**: if `rq`=1, store `ad` into bits [31:24] and go to PAY. If `rq`=0, the packet is address-only; go to END.
- **PAY**: byte k (k=0..`PAYLOAD_BYTES`-1) is stored into bits [8k+7:8k].
  - Bytes beyond `PAYLOAD_BYTES` are ignored.
  - Unreceived payload bytes stay 0.
  - Leave for END when `rq`=0.
- **END**: copy the address and word into the write stage, then go to IDLE. If `start` is seen in this cycle, capture the new address and go to SEQ.

Write stage (one cycle after END):
- If the address < 2^`STATUS_DEPTH`, write the word to the RAM.
- Otherwise discard the word and increment the drop count. The drop count is 8-bit and saturates at 255.
- If the address < `IRQ_CELLS`, set `pending`[address].

Interrupt logic:
- `irq` is a register equal to |(`pending` & `mask`).
- Mask set/clear: each 1 bit in `cmd_wdata` sets or clears the corresponding mask bit.
- W1C on pending: each 1 bit in `cmd_wdata` clears the corresponding pending bit.
- If a pending set and a W1C clear hit the same bit in the same cycle, the set wins.

Read port:
- `rd_data` is a registered RAM output.
- A read and a write to the same address in the same cycle return the old word.

Reset (`rst`=0):
- FSM returns to IDLE.
- Write stage is idle.
- `mask`, `pending`, drop count, `irq`, `rd_valid`, `rd_data`, and `cmd_rdata` are all 0.
- `start` is 0 during reset, because `rq_r` is held 0 and `start` is gated by `rst`.
- RAM contents are not reset.
- Reset mid-packet abandons the packet; no write occurs.

## Timing
- Edge numbering: edge S samples `start`. Packet bytes arrive on edges S+1..; edge E is the first edge that samples `rq`=0.
- END is active in the cycle following E.
- The RAM write and the pending set occur on edge E+1.
- `irq` rises after edge E+2 when the mask bit is set.
- Minimum `rq`-low gap between packets: 1 cycle, with no loss.
- `rd_valid`/`rd_data` appear 1 cycle after `rd_en`.
- `cmd_rdata` updates 1 cycle after `cmd_addr`.
- A control write takes effect on the edge sampling `cmd_we`; its effect on `irq` is visible one edge later.

## Structure
- Package `status_read_irq_pkg` holds:
  - the FSM state enum {IDLE, SEQ, PAY, END};
  - `cmd_addr` constants CMD_MASK_SET=0, CMD_MASK_CLR=1, CMD_PEND_W1C=2, CMD_DROP=3.
- Sub-module `status_byte_deser`: contains the FSM, `start`, and the assembly word. It outputs a one-cycle `pkt_valid` with `pkt_addr`[7:0] and `pkt_word`[31:0].
- The top level holds the RAM, interrupt registers, drop counter, and the control/read ports.

## Test plan
- Full packet: addr 0x05, seq 0xA4, payload 0x11 0x22 0x33 -> RAM[5]=0xA4332211 written at E+1; `rd_data`=0xA4332211 one cycle after `rd_en`.
- Short packets with `PAYLOAD_BYTES`=3:
  - address-only packet to 0x07 -> RAM[7]=0x00000000;
  - packet addr 0x08, seq 0x80, payload 0x5A -> RAM[8]=0x8000005A.
- Overlong packet with `PAYLOAD_BYTES`=2: addr 0x03, seq 0x01, payload 0xAA 0xBB 0xCC -> RAM[3]=0x0100BBAA.
- Back-to-back packets to 0x01 then 0x02 with a 1-cycle `rq` gap -> both RAM words correct and 2 writes.
- Interrupts:
  - mask set 0x0004, then packet to address 2 -> `irq` high after E+2;
  - W1C 0x4 -> `irq` low;
  - W1C of bit 2 on the same cycle as a new set -> pending stays 1.
- Address 0x50 with `STATUS_DEPTH`=6 -> no RAM write and drop count = 1. After 300 such packets -> drop count = 255. Then `rst`=0 mid-packet -> no write, drop count = 0, `irq`=0.

Source files
------------

// File: rtl/status_read_irq_pkg.sv
// Shared types and constants for the status collector: deserializer states and
// control register selects.
package status_read_irq_pkg;

  typedef enum logic [1:0] {IDLE, SEQ, PAY, END} deser_state_e;

  localparam logic [1:0] CMD_MASK_SET = 2'd0;
  localparam logic [1:0] CMD_MASK_CLR = 2'd1;
  localparam logic [1:0] CMD_PEND_W1C = 2'd2;
  localparam logic [1:0] CMD_DROP     = 2'd3;

endpackage

// File: rtl/status_byte_deser.sv
// Byte-serial packet deserializer: address, sequence byte, then payload bytes,
// presented as a one-cycle pkt_valid in the END state.
module status_byte_deser
  import status_read_irq_pkg::*;
#(
  parameter int PAYLOAD_BYTES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ad,
  input  logic        rq,
  output logic        start,
  output logic        pkt_valid,
  output logic [7:0]  pkt_addr,
  output logic [31:0] pkt_word
);

  localparam logic [2:0] PB = 3'(PAYLOAD_BYTES);

  deser_state_e state, state_nxt;
  logic         rq_r;
  logic         load, seq_we, pay_we;
  logic [1:0]   byte_cnt;
  logic [7:0]   addr_q;
  logic [31:0]  word_q;

  assign start = rst && rq && !rq_r;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      rq_r  <= 1'b0;
    end else begin
      state <= state_nxt;
      rq_r  <= rq;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    seq_we    = 1'b0;
    pay_we    = 1'b0;
    case (state)
      IDLE: if (start) begin
        load      = 1'b1;
        state_nxt = SEQ;
      end
      SEQ: if (rq) begin
        seq_we    = 1'b1;
        state_nxt = PAY;
      end else begin
        state_nxt = END;
      end
      PAY: if (rq) pay_we = 1'b1;
           else    state_nxt = END;
      END: begin
        // a new packet may start while the previous one is being handed off
        state_nxt = IDLE;
        if (start) begin
          load      = 1'b1;
          state_nxt = SEQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // byte_cnt saturates so overlong payloads never wrap onto stored bytes
  always_ff @(posedge clk) begin
    if (load) begin
      addr_q   <= ad;
      word_q   <= '0;
      byte_cnt <= '0;
    end else if (seq_we) begin
      word_q[31:24] <= ad;
    end else if (pay_we) begin
      if ({1'b0, byte_cnt} < PB) word_q[{byte_cnt, 3'b000} +: 8] <= ad;
      if (byte_cnt != 2'd3) byte_cnt <= byte_cnt + 2'd1;
    end
  end

  assign pkt_valid = (state == END);
  assign pkt_addr  = addr_q;
  assign pkt_word  = word_q;

endmodule

// File: rtl/status_read_irq.sv
// Status RAM with byte-serial fill, registered read port, per-cell interrupt
// pending/mask registers and a saturating drop counter for out-of-range packets.
module status_read_irq
  import status_read_irq_pkg::*;
#(
  parameter int STATUS_DEPTH  = 6,
  parameter int PAYLOAD_BYTES = 3,
  parameter int IRQ_CELLS     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              ad,
  input  logic                    rq,
  output logic                    start,
  input  logic [STATUS_DEPTH-1:0] rd_addr,
  input  logic                    rd_en,
  output logic [31:0]             rd_data,
  output logic                    rd_valid,
  input  logic                    cmd_we,
  input  logic [1:0]              cmd_addr,
  input  logic [31:0]             cmd_wdata,
  output logic [31:0]             cmd_rdata,
  output logic                    irq
);

  localparam int CELLS = 1 << STATUS_DEPTH;
  localparam logic [IRQ_CELLS-1:0] ONE = IRQ_CELLS'(1);

  logic                 pkt_valid;
  logic [7:0]           pkt_addr;
  logic [31:0]          pkt_word;
  logic [31:0]          ram [CELLS];
  logic [IRQ_CELLS-1:0] mask, pending, mask_nxt, pend_nxt, pend_set, wbits;
  logic [7:0]           drop_cnt;
  logic                 in_range, wr_en;
  logic                 unused_bits;

  status_byte_deser #(.PAYLOAD_BYTES(PAYLOAD_BYTES)) u_deser (
    .clk       (clk),
    .rst       (rst),
    .ad        (ad),
    .rq        (rq),
    .start     (start),
    .pkt_valid (pkt_valid),
    .pkt_addr  (pkt_addr),
    .pkt_word  (pkt_word)
  );

  // not every parameter set consumes all address/data bits
  assign unused_bits = ^{cmd_wdata, pkt_addr};

  assign in_range = {1'b0, pkt_addr} < 9'(CELLS);
  assign wr_en    = pkt_valid && rst && in_range;
  // shifting past IRQ_CELLS yields zero, so high addresses raise nothing
  assign pend_set = pkt_valid ? (ONE << pkt_addr) : '0;
  assign wbits    = cmd_wdata[IRQ_CELLS-1:0];

  always_comb begin
    mask_nxt = mask;
    pend_nxt = pending;
    if (cmd_we) begin
      case (cmd_addr)
        CMD_MASK_SET: mask_nxt = mask | wbits;
        CMD_MASK_CLR: mask_nxt = mask & ~wbits;
        CMD_PEND_W1C: pend_nxt = pending & ~wbits;
        default: ;
      endcase
    end
    pend_nxt = pend_nxt | pend_set;
  end

  always_ff @(posedge clk) begin
    if (wr_en) ram[pkt_addr[STATUS_DEPTH-1:0]] <= pkt_word;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mask      <= '0;
      pending   <= '0;
      drop_cnt  <= '0;
      irq       <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      cmd_rdata <= '0;
    end else begin
      mask     <= mask_nxt;
      pending  <= pend_nxt;
      irq      <= |(pending & mask);
      rd_valid <= rd_en;
      if (rd_en) rd_data <= ram[rd_addr];
      if (pkt_valid && !in_range && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      case (cmd_addr)
        CMD_MASK_SET: cmd_rdata <= 32'(mask);
        CMD_MASK_CLR: cmd_rdata <= 32'(pending);
        CMD_PEND_W1C: cmd_rdata <= 32'(pending & mask);
        default:      cmd_rdata <= {24'd0, drop_cnt};
      endcase
    end
  end

endmodule

// File: tb/tb_status_read_irq.sv
// Randomized and directed bench for status_read_irq with a packet-level model.
module tb_status_read_irq;

  localparam int SD = 6;
  localparam int PB = 3;
  localparam int IC = 16;

  logic          clk = 1'b0;
  logic          rst, rq, rd_en, cmd_we;
  logic [7:0]    ad;
  logic [SD-1:0] rd_addr;
  logic [1:0]    cmd_addr;
  logic [31:0]   cmd_wdata;
  logic          start, rd_valid, irq;
  logic [31:0]   rd_data, cmd_rdata;

  status_read_irq #(.STATUS_DEPTH(SD), .PAYLOAD_BYTES(PB), .IRQ_CELLS(IC)) dut (
    .clk       (clk),
    .rst       (rst),
    .ad        (ad),
    .rq        (rq),
    .start     (start),
    .rd_addr   (rd_addr),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_rdata (cmd_rdata),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] word;
    int          when;
  } wr_t;

  // reference state
  wr_t         q[$];
  logic [31:0] mram [1<<SD];
  bit          mknown [1<<SD];
  logic [15:0] mmask, mpend;
  int          mdrop;
  bit          m_rqprev;
  logic [31:0] exp_rd, exp_cr;
  bit          exp_rv, exp_irq, exp_rd_known;
  int          cyc = 0;
  bit          started = 0;
  bit          bg_en = 0;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare();
    if (started) begin
      chk("start", 32'(start), 32'(rst && rq && !m_rqprev));
      chk("irq", 32'(irq), 32'(exp_irq));
      chk("rd_valid", 32'(rd_valid), 32'(exp_rv));
      chk("cmd_rdata", cmd_rdata, exp_cr);
      if (exp_rd_known) chk("rd_data", rd_data, exp_rd);
    end
  endtask

  // one clock edge worth of specified behaviour, from inputs sampled at that edge
  task automatic model_step();
    wr_t p;
    cyc++;
    started = 1;
    if (!rst) begin
      m_rqprev = 0; exp_irq = 0; exp_rv = 0; exp_rd = 0; exp_rd_known = 1;
      exp_cr = 0; mmask = 0; mpend = 0; mdrop = 0;
      q.delete();
    end else begin
      exp_irq = |(mpend & mmask);
      case (cmd_addr)
        2'd0:    exp_cr = {16'd0, mmask};
        2'd1:    exp_cr = {16'd0, mpend};
        2'd2:    exp_cr = {16'd0, mpend & mmask};
        default: exp_cr = 32'(mdrop);
      endcase
      exp_rv = rd_en;
      if (rd_en) begin
        exp_rd       = mram[rd_addr];
        exp_rd_known = mknown[rd_addr];
      end
      if (cmd_we) begin
        case (cmd_addr)
          2'd0: mmask = mmask | cmd_wdata[15:0];
          2'd1: mmask = mmask & ~cmd_wdata[15:0];
          2'd2: mpend = mpend & ~cmd_wdata[15:0];
          default: ;
        endcase
      end
      if (q.size() > 0 && q[0].when == cyc) begin
        p = q.pop_front();
        if (p.addr < (1 << SD)) begin
          mram[p.addr]   = p.word;
          mknown[p.addr] = 1;
        end else if (mdrop < 255) begin
          mdrop++;
        end
        if (p.addr < IC) mpend[p.addr] = 1'b1;
      end
      m_rqprev = rq;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_step();
    #1;
    if (bg_en) begin
      rd_en     = 1'($urandom_range(0, 1));
      rd_addr   = SD'($urandom_range(0, (1 << SD) - 1));
      cmd_we    = ($urandom_range(0, 5) == 0);
      cmd_addr  = 2'($urandom_range(0, 3));
      cmd_wdata = $urandom;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // n = bytes after the address (0: address-only, 1: sequence byte only, ...)
  task automatic send_pkt(input int addr, input int n, input logic [63:0] b);
    logic [31:0] w;
    w = '0;
    tick(); rq = 1'b1; ad = 8'(addr);
    for (int i = 0; i < n; i++) begin
      tick();
      ad = b[8*i +: 8];
      if (i == 0)          w[31:24] = b[7:0];
      else if (i - 1 < PB) w[8*(i-1) +: 8] = b[8*i +: 8];
    end
    tick(); rq = 1'b0; ad = 8'($urandom);
    // first edge seeing rq low is cyc+1; the write lands one edge later
    q.push_back('{addr, w, cyc + 2});
  endtask

  task automatic read_lit(input string name, input int a, input logic [31:0] exp);
    rd_en = 1'b1; rd_addr = SD'(a);
    tick();
    rd_en = 1'b0;
    chk(name, rd_data, exp);
  endtask

  task automatic cmd_lit(input string name, input logic [1:0] sel, input logic [31:0] exp);
    cmd_addr = sel;
    tick();
    chk(name, cmd_rdata, exp);
  endtask

  task automatic cmd_wr(input logic [1:0] sel, input logic [31:0] d);
    cmd_we = 1'b1; cmd_addr = sel; cmd_wdata = d;
    tick();
    cmd_we = 1'b0;
  endtask

  initial begin
    rst = 1'b0; rq = 1'b0; ad = '0; rd_en = 1'b0; rd_addr = '0;
    cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    idle(3);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_cmd_rdata", cmd_rdata, 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    rst = 1'b1;
    idle(2);

    send_pkt(5, 4, 64'h33_22_11_A4);
    idle(3);
    read_lit("full_pkt", 5, 32'hA433_2211);

    send_pkt(7, 0, 64'd0);
    send_pkt(8, 2, 64'h5A_80);
    idle(3);
    read_lit("addr_only", 7, 32'h0000_0000);
    read_lit("short_pkt", 8, 32'h8000_005A);

    send_pkt(3, 5, 64'hDD_CC_BB_AA_01);
    idle(3);
    read_lit("overlong", 3, 32'h01CC_BBAA);

    send_pkt(1, 2, 64'h11_11);
    send_pkt(2, 3, 64'h33_22_20);
    idle(3);
    read_lit("b2b_first", 1, 32'h1100_0011);
    read_lit("b2b_second", 2, 32'h2000_3322);

    cmd_wr(2'd2, 32'hFFFF);
    cmd_wr(2'd0, 32'h4);
    idle(2);
    chk("irq_before_pkt", 32'(irq), 32'd0);
    send_pkt(2, 1, 64'h42);
    idle(3);
    chk("irq_raised", 32'(irq), 32'd1);
    cmd_wr(2'd2, 32'h4);
    idle(2);
    chk("irq_w1c", 32'(irq), 32'd0);

    send_pkt(2, 0, 64'd0);
    tick();
    cmd_wr(2'd2, 32'h4);
    cmd_addr = 2'd1;
    tick();
    chk("pend_set_wins", cmd_rdata & 32'h4, 32'h4);
    idle(2);
    chk("irq_after_tie", 32'(irq), 32'd1);

    send_pkt(8'h50, 0, 64'd0);
    idle(3);
    cmd_lit("drop_one", 2'd3, 32'd1);

    bg_en = 1;
    repeat (150) begin
      send_pkt($urandom_range(0, 95), $urandom_range(0, 5), {$urandom, $urandom});
      idle($urandom_range(0, 2));
    end
    bg_en = 0;
    rd_en = 1'b0; cmd_we = 1'b0;
    idle(3);

    repeat (300) send_pkt(8'h50, 0, 64'd0);
    idle(3);
    cmd_lit("drop_sat", 2'd3, 32'd255);

    send_pkt(9, 2, 64'h01_99);
    idle(3);
    tick(); rq = 1'b1; ad = 8'd9;
    tick(); ad = 8'h77;
    tick(); ad = 8'h12;
    tick(); rst = 1'b0; rq = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(2);
    cmd_lit("drop_after_rst", 2'd3, 32'd0);
    chk("irq_after_rst", 32'(irq), 32'd0);
    read_lit("no_write_on_rst", 9, 32'h9900_0001);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
